// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state/owner encodings and widths for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam int STARVE_W = 4;
  function automatic owner_t owner_of(state_t s);
    return s == BUSY_IF ? OWN_IF : s == BUSY_D ? OWN_D : OWN_NONE;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory port bundle; master = arbiter side
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              spurious;
  modport master (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, spurious
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, spurious
  );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// mem_arb_prio: combinational grant selector, D first unless IF is starved
module mem_arb_prio (
  input  logic if_req,
  input  logic d_req,
  input  logic starved,
  input  logic window,
  output logic gnt_if,
  output logic gnt_d
);
  always_comb begin
    gnt_if = window && if_req && (!d_req || starved);
    gnt_d = window && d_req && !gnt_if;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory shared by fetch and load/store; ARB_PERF_CNT_EN adds perf counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] d_stall_cnt,
  output logic [31:0] xfer_cnt
`endif
);
  state_t state;
  owner_t owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic window, starved, gnt_if, gnt_d, if_rv, d_rv, spurious;
  assign owner = owner_of(state);
  assign starved = starve_cnt == STARVE_W'(STARVE_MAX);
  // a response cycle reopens the port so the next access issues back-to-back
  assign window = !rst && (state == IDLE || bus.mem_rvalid);
  mem_arb_prio u_prio (
    .if_req(bus.if_req),
    .d_req(bus.d_req),
    .starved(starved),
    .window(window),
    .gnt_if(gnt_if),
    .gnt_d(gnt_d)
  );
  always_comb begin
    if_rv = owner == OWN_IF && bus.mem_rvalid;
    d_rv = owner == OWN_D && bus.mem_rvalid;
    bus.if_gnt = gnt_if;
    bus.d_gnt = gnt_d;
    bus.mem_req = gnt_if || gnt_d;
    bus.mem_we = gnt_d && bus.d_we;
    bus.mem_be = gnt_d ? bus.d_be : {(DATA_W/8){gnt_if}};
    bus.mem_addr = gnt_d ? bus.d_addr : gnt_if ? bus.if_addr : {ADDR_W{1'b0}};
    bus.mem_wdata = gnt_d ? bus.d_wdata : {DATA_W{1'b0}};
    bus.if_rvalid = if_rv;
    bus.d_rvalid = d_rv;
    bus.if_rdata = if_rv ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.d_rdata = d_rv ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.spurious = spurious;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      spurious <= 1'b0;
    end else begin
      state <= gnt_if ? BUSY_IF : gnt_d ? BUSY_D : window ? IDLE : state;
      starve_cnt <= (!bus.if_req || gnt_if) ? '0 : (gnt_d && !starved) ? starve_cnt + 1'b1 : starve_cnt;
      spurious <= spurious || (state == IDLE && bus.mem_rvalid);
    end
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_stall_cnt <= '0;
      d_stall_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      if_stall_cnt <= if_stall_cnt + 32'(bus.if_req && !gnt_if);
      d_stall_cnt <= d_stall_cnt + 32'(bus.d_req && !gnt_d);
      xfer_cnt <= xfer_cnt + 32'(gnt_if || gnt_d);
    end
`endif
endmodule
